// File: rtl/rv_debug_pkg.sv
// Shared definitions for the RV32 debug sequencer.
// Holds the host command encodings, the controller state enum and the
// debug-port widths used by the RV32 core.
package rv_debug_pkg;

   localparam int DBG_ADDR_W = 7;
   localparam int DBG_DATA_W = 32;

   typedef enum logic [1:0] {
      OP_RUN  = 2'b00,
      OP_HALT = 2'b01,
      OP_STEP = 2'b10,
      OP_DUMP = 2'b11
   } dbg_op_e;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_HALTED,
      ST_HALT_ENTRY,
      ST_STEP_PULSE,
      ST_STEP_GAP_WAIT,
      ST_DUMP_WAIT,
      ST_DUMP_RSP
   } dbg_state_e;

endpackage

// File: rtl/dbg_step_gen.sv
// Step pulse generator: emits n single-cycle pulses spaced STEP_GAP cycles
// apart, then holds off STEP_GAP-1 cycles after the last pulse.
// Ports:
//   clk, rst  clock, async active-low reset
//   start, n  launch a burst of n pulses (n = 0 does nothing)
//   step      registered pulse output
//   busy      burst in progress (pulses or trailing gap)
//   fire      next edge starts another pulse
//   done      next edge ends the burst
module dbg_step_gen #(
   parameter int STEP_GAP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] n,
   output logic       step,
   output logic       busy,
   output logic       fire,
   output logic       done
);

   localparam int GW = $clog2(STEP_GAP);
   localparam logic [GW-1:0] GAP_LOAD = GW'(STEP_GAP - 1);

   logic [7:0]    rem_q;
   logic [GW-1:0] gap_q;

   assign fire = busy && (gap_q == '0) && (rem_q != 8'd0);
   assign done = busy && (gap_q == '0) && (rem_q == 8'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step  <= 1'b0;
         busy  <= 1'b0;
         rem_q <= 8'd0;
         gap_q <= '0;
      end else if (start) begin
         step  <= |n;
         busy  <= |n;
         rem_q <= (n == 8'd0) ? 8'd0 : n - 8'd1;
         gap_q <= GAP_LOAD;
      end else if (busy) begin
         if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
            step  <= 1'b0;
         end else if (rem_q != 8'd0) begin
            step  <= 1'b1;
            rem_q <= rem_q - 8'd1;
            gap_q <= GAP_LOAD;
         end else begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rv_debug_ctrl.sv
// Command-driven debug sequencer for the RV32 core debug port.
// Turns host RUN / HALT / STEP / DUMP commands into debug_en, debug_step and
// debug_addr signalling and returns dumped words over a valid/ready stream.
// Ports:
//   clk, rst                      clock, async active-low reset
//   cmd_valid/ready/op/arg        host command channel
//   dbg_en, dbg_step, dbg_addr    to core debug port
//   dbg_data                      from core debug port
//   rsp_valid/ready/addr/data/last  dump word stream
//   halted                        mirrors dbg_en
//
// state            | meaning
// ST_RUN           | core free-running, commands accepted
// ST_HALTED        | core halted, commands accepted
// ST_HALT_ENTRY    | one-cycle halt before a STEP/DUMP issued while running
// ST_STEP_PULSE    | dbg_step high this cycle
// ST_STEP_GAP_WAIT | spacing between pulses / tail after the last pulse
// ST_DUMP_WAIT     | dbg_addr held while core read data settles
// ST_DUMP_RSP      | captured word offered on rsp_*, waiting for rsp_ready
module rv_debug_ctrl
   import rv_debug_pkg::*;
#(
   parameter int ADDR_W       = DBG_ADDR_W,
   parameter int DATA_W       = DBG_DATA_W,
   parameter int DUMP_LEN     = 32,
   parameter int READ_LAT     = 1,
   parameter int STEP_GAP     = 2,
   parameter bit RESET_HALTED = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [7:0]        cmd_arg,
   output logic              dbg_en,
   output logic              dbg_step,
   output logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              halted
);

   localparam int CW = ADDR_W + 1;
   // A zero-latency read still needs the address on the bus for one cycle
   // before capture, so READ_LAT 0 and 1 share the same wait.
   localparam logic [2:0]    LAT_LOAD  = (READ_LAT > 1) ? 3'(READ_LAT - 1) : 3'd0;
   localparam logic [CW-1:0] BEAT_LOAD = CW'(DUMP_LEN - 1);
   localparam dbg_state_e    RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

   dbg_state_e state_q, state_d;
   dbg_op_e    pend_op_q, pend_op_d, launch_op;
   logic [7:0] pend_arg_q, pend_arg_d, launch_arg;
   logic [2:0] lat_q, lat_d;
   logic [CW-1:0] beat_q, beat_d;

   logic              dbg_en_d, cmd_ready_d, rsp_valid_d, rsp_last_d;
   logic [ADDR_W-1:0] dbg_addr_d, rsp_addr_d;
   logic [DATA_W-1:0] rsp_data_d;

   logic accept, launch, step_start, dump_start, capture, beat_done, dump_end;
   logic step_busy, step_fire, step_done;

   assign halted     = dbg_en;
   assign accept     = cmd_valid && cmd_ready;
   // HALT_ENTRY replays the latched command as if it arrived in HALTED.
   assign launch     = (state_q == ST_HALT_ENTRY) || (state_q == ST_HALTED && accept);
   assign launch_op  = (state_q == ST_HALT_ENTRY) ? pend_op_q : dbg_op_e'(cmd_op);
   assign launch_arg = (state_q == ST_HALT_ENTRY) ? pend_arg_q : cmd_arg;
   assign step_start = launch && (launch_op == OP_STEP) && (|launch_arg);
   assign dump_start = launch && (launch_op == OP_DUMP);
   assign capture    = (state_q == ST_DUMP_WAIT) && (lat_q == 3'd0);
   assign beat_done  = (state_q == ST_DUMP_RSP) && rsp_ready;
   assign dump_end   = beat_done && (beat_q == '0);

   dbg_step_gen #(.STEP_GAP(STEP_GAP)) u_step_gen (
      .clk   (clk),
      .rst   (rst),
      .start (step_start),
      .n     (launch_arg),
      .step  (dbg_step),
      .busy  (step_busy),
      .fire  (step_fire),
      .done  (step_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RST_STATE;
         dbg_en     <= RESET_HALTED;
         cmd_ready  <= 1'b1;
         dbg_addr   <= '0;
         rsp_valid  <= 1'b0;
         rsp_last   <= 1'b0;
         rsp_addr   <= '0;
         rsp_data   <= '0;
         lat_q      <= 3'd0;
         beat_q     <= '0;
         pend_op_q  <= OP_RUN;
         pend_arg_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         dbg_en     <= dbg_en_d;
         cmd_ready  <= cmd_ready_d;
         dbg_addr   <= dbg_addr_d;
         rsp_valid  <= rsp_valid_d;
         rsp_last   <= rsp_last_d;
         rsp_addr   <= rsp_addr_d;
         rsp_data   <= rsp_data_d;
         lat_q      <= lat_d;
         beat_q     <= beat_d;
         pend_op_q  <= pend_op_d;
         pend_arg_q <= pend_arg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (accept) begin
               if (dbg_op_e'(cmd_op) == OP_HALT)
                  state_d = ST_HALTED;
               else if (dbg_op_e'(cmd_op) != OP_RUN)
                  state_d = ST_HALT_ENTRY;
            end
         end
         ST_HALTED, ST_HALT_ENTRY: begin
            if (launch) begin
               if (step_start)              state_d = ST_STEP_PULSE;
               else if (dump_start)         state_d = ST_DUMP_WAIT;
               else if (launch_op == OP_RUN) state_d = ST_RUN;
               else                         state_d = ST_HALTED;
            end
         end
         ST_STEP_PULSE:    state_d = ST_STEP_GAP_WAIT;
         ST_STEP_GAP_WAIT: begin
            if (step_done || !step_busy) state_d = ST_HALTED;
            else if (step_fire)          state_d = ST_STEP_PULSE;
         end
         ST_DUMP_WAIT: begin
            if (capture) state_d = ST_DUMP_RSP;
         end
         ST_DUMP_RSP: begin
            if (beat_done) state_d = dump_end ? ST_HALTED : ST_DUMP_WAIT;
         end
         default: state_d = RST_STATE;
      endcase
   end

   always_comb begin
      dbg_en_d    = (state_d != ST_RUN);
      cmd_ready_d = (state_d == ST_RUN) || (state_d == ST_HALTED);
      dbg_addr_d  = dbg_addr;
      lat_d       = lat_q;
      beat_d      = beat_q;
      rsp_valid_d = rsp_valid;
      rsp_last_d  = rsp_last;
      rsp_addr_d  = rsp_addr;
      rsp_data_d  = rsp_data;
      pend_op_d   = pend_op_q;
      pend_arg_d  = pend_arg_q;

      if (state_q == ST_RUN && accept) begin
         pend_op_d  = dbg_op_e'(cmd_op);
         pend_arg_d = cmd_arg;
      end

      if (dump_start) begin
         dbg_addr_d = launch_arg[ADDR_W-1:0];
         lat_d      = LAT_LOAD;
         beat_d     = BEAT_LOAD;
      end else if (beat_done && !dump_end) begin
         dbg_addr_d = dbg_addr + ADDR_W'(1);
         lat_d      = LAT_LOAD;
         beat_d     = beat_q - CW'(1);
      end else if (state_q == ST_DUMP_WAIT && lat_q != 3'd0) begin
         lat_d = lat_q - 3'd1;
      end

      if (capture) begin
         rsp_valid_d = 1'b1;
         rsp_last_d  = (beat_q == '0);
         rsp_addr_d  = dbg_addr;
         rsp_data_d  = dbg_data;
      end else if (beat_done) begin
         rsp_valid_d = 1'b0;
         rsp_last_d  = 1'b0;
      end
   end

endmodule
